// File: rtl/axi4l2core_if.sv
// AXI4-Lite slave bundle plus the core-side req/gnt/rvalid memory port.
// slave: the bridge side; master: interconnect plus memory model side.
interface axi4l2core_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;
   logic                    mem_req;
   logic                    mem_gnt;
   logic                    mem_we;
   logic [DATA_WIDTH/8-1:0] mem_be;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic                    mem_rvalid;
   logic [DATA_WIDTH-1:0]   mem_rdata;
   logic                    mem_err;

   modport slave (
      input  awaddr, awprot, awvalid,
      output awready,
      input  wdata, wstrb, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready,
      input  araddr, arprot, arvalid,
      output arready,
      output rdata, rresp, rvalid,
      input  rready,
      output mem_req, mem_we, mem_be,
      output mem_addr, mem_wdata,
      input  mem_gnt, mem_rvalid,
      input  mem_rdata, mem_err
   );

   modport master (
      output awaddr, awprot, awvalid,
      input  awready,
      output wdata, wstrb, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready,
      output araddr, arprot, arvalid,
      input  arready,
      input  rdata, rresp, rvalid,
      output rready,
      input  mem_req, mem_we, mem_be,
      input  mem_addr, mem_wdata,
      output mem_gnt, mem_rvalid,
      output mem_rdata, mem_err
   );
endinterface

// File: rtl/axi4l2core.sv
// AXI4-Lite responder driving a core-style req/gnt/rvalid memory port.
// One transaction in flight; AW, W and AR each own a one-entry slot.
module axi4l2core #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input logic          aclk,
   input logic          aresetn,
   axi4l2core_if.slave  bus
);
   localparam int SW = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      IDLE, MEM_REQ, MEM_WAIT, RESP_R, RESP_B
   } state_t;

   state_t                state;
   logic                  live;
   logic                  aw_full, w_full, ar_full;
   logic                  prio_wr;
   logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
   logic [DATA_WIDTH-1:0] w_data;
   logic [SW-1:0]         w_strb;
   logic                  wr_pend, pick_rd;
   logic                  unused_prot;

   assign unused_prot = ^{bus.awprot, bus.arprot};

   // live keeps every ready low while reset is held
   assign bus.awready = live & ~aw_full;
   assign bus.wready  = live & ~w_full;
   assign bus.arready = live & ~ar_full;

   assign wr_pend = aw_full & w_full;
   assign pick_rd = ar_full & (~wr_pend | ~prio_wr);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state         <= IDLE;
         live          <= 1'b0;
         aw_full       <= 1'b0;
         w_full        <= 1'b0;
         ar_full       <= 1'b0;
         prio_wr       <= 1'b0;
         aw_addr       <= '0;
         ar_addr       <= '0;
         w_data        <= '0;
         w_strb        <= '0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_be    <= '0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.bvalid    <= 1'b0;
         bus.bresp     <= 2'b00;
         bus.rvalid    <= 1'b0;
         bus.rresp     <= 2'b00;
         bus.rdata     <= '0;
      end else begin
         live <= 1'b1;
         if (bus.awvalid && bus.awready) begin
            aw_full <= 1'b1;
            aw_addr <= bus.awaddr;
         end
         if (bus.wvalid && bus.wready) begin
            w_full <= 1'b1;
            w_data <= bus.wdata;
            w_strb <= bus.wstrb;
         end
         if (bus.arvalid && bus.arready) begin
            ar_full <= 1'b1;
            ar_addr <= bus.araddr;
         end
         unique case (state)
            IDLE: begin
               if (pick_rd) begin
                  bus.mem_we    <= 1'b0;
                  bus.mem_addr  <= ar_addr;
                  bus.mem_be    <= '1;
                  bus.mem_wdata <= '0;
                  bus.mem_req   <= 1'b1;
                  prio_wr       <= 1'b1;
                  state         <= MEM_REQ;
               end else if (wr_pend) begin
                  bus.mem_we    <= 1'b1;
                  bus.mem_addr  <= aw_addr;
                  bus.mem_be    <= w_strb;
                  bus.mem_wdata <= w_data;
                  bus.mem_req   <= 1'b1;
                  prio_wr       <= 1'b0;
                  state         <= MEM_REQ;
               end
            end
            MEM_REQ: begin
               if (bus.mem_gnt) begin
                  bus.mem_req <= 1'b0;
                  state       <= MEM_WAIT;
               end
            end
            MEM_WAIT: begin
               if (bus.mem_rvalid) begin
                  if (bus.mem_we) begin
                     bus.bresp  <= {bus.mem_err, 1'b0};
                     bus.bvalid <= 1'b1;
                     aw_full    <= 1'b0;
                     w_full     <= 1'b0;
                     state      <= RESP_B;
                  end else begin
                     bus.rdata  <= bus.mem_rdata;
                     bus.rresp  <= {bus.mem_err, 1'b0};
                     bus.rvalid <= 1'b1;
                     ar_full    <= 1'b0;
                     state      <= RESP_R;
                  end
               end
            end
            RESP_R: begin
               if (bus.rready) begin
                  bus.rvalid <= 1'b0;
                  state      <= IDLE;
               end
            end
            RESP_B: begin
               if (bus.bready) begin
                  bus.bvalid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
